booth_r4_mult: RTL and testbench

//  Sequential radix-4 (modified) Booth multiplier with integrated controller and start/done handshake.

---
 rtl/booth_r4_mult.sv | 148 ++++++++++++++
 tb/tb_booth_r4_mult.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 (modified) Booth multiplier with a start/done handshake.
// Operands are extended by two bits so the most-negative signed value and the
// full unsigned range both reduce to the same signed recoding. The core retires
// two multiplier bits per cycle.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; operands are sampled on acceptance
//   S_RUN  | one Booth step per cycle (add/sub partial, shift right by 2)
//   S_DONE | product just latched; done pulse; start is ignored here
module booth_r4_mult #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int E    = WIDTH + 2;      // extended operand width
  localparam int AW   = E + 2;          // accumulator width (headroom for +/-2M)
  localparam int ITER = E / 2;          // Booth steps per product
  localparam int CW   = $clog2(ITER + 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("booth_r4_mult: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_a;
  logic [AW-1:0]       r_m;
  logic [E-1:0]        r_q;
  logic                r_q_m1;
  logic [CW-1:0]       r_count;
  logic                r_busy;
  logic                r_done;
  logic [2*WIDTH-1:0]  r_product;

  logic [E-1:0]        w_mx;
  logic [E-1:0]        w_qx;
  logic [2:0]          w_trip;
  logic [AW-1:0]       w_m2;
  logic [AW-1:0]       w_addend;
  logic [AW-1:0]       w_sum;
  logic [AW-1:0]       w_a_nxt;
  logic [E-1:0]        w_q_nxt;

  // Operand extension: sign bits in signed mode, zeros otherwise.
  always_comb begin
    if (signed_mode) begin
      w_mx = {{2{multiplicand[WIDTH-1]}}, multiplicand};
      w_qx = {{2{multiplier[WIDTH-1]}}, multiplier};
    end else begin
      w_mx = {2'b00, multiplicand};
      w_qx = {2'b00, multiplier};
    end
  end

  assign w_trip = {r_q[1:0], r_q_m1};
  assign w_m2   = {r_m[AW-2:0], 1'b0};

  // Booth recoding of the current bit triple into the partial to add.
  always_comb begin
    w_addend = '0;
    case (w_trip)
      3'b001, 3'b010: w_addend = r_m;
      3'b011:         w_addend = w_m2;
      3'b100:         w_addend = -w_m2;
      3'b101, 3'b110: w_addend = -r_m;
      default:        w_addend = '0;
    endcase
  end

  // Add, then arithmetic shift of {A,Q,q_m1} right by two.
  always_comb begin
    w_sum   = r_a + w_addend;
    w_a_nxt = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    w_q_nxt = {w_sum[1:0], r_q[E-1:2]};
  end

  // Controller and datapath registers with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q_m1    <= 1'b0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= {{2{w_mx[E-1]}}, w_mx};
            r_q     <= w_qx;
            r_a     <= '0;
            r_q_m1  <= 1'b0;
            r_count <= CW'(ITER);
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= w_a_nxt;
          r_q     <= w_q_nxt;
          r_q_m1  <= r_q[1];
          r_count <= r_count - 1'b1;
          if (r_count == CW'(1)) begin
            // Final step: the shifted value already holds the full product.
            r_product <= {w_a_nxt[WIDTH-3:0], w_q_nxt};
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_booth_r4_mult.sv
// Bench for booth_r4_mult at WIDTH=16 (directed + random), WIDTH=4 (exhaustive)
// and WIDTH=32 (random). Expected products come from plain 64-bit arithmetic.
module tb_booth_r4_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_v [3];
  logic        sm_v    [3];
  logic [31:0] m_v     [3];
  logic [31:0] q_v     [3];

  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [31:0] prod0;
  logic [7:0]  prod1;
  logic [63:0] prod2;

  booth_r4_mult #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm_v[0]),
    .multiplicand(m_v[0][15:0]), .multiplier(q_v[0][15:0]),
    .busy(busy0), .done(done0), .product(prod0));

  booth_r4_mult #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm_v[1]),
    .multiplicand(m_v[1][3:0]), .multiplier(q_v[1][3:0]),
    .busy(busy1), .done(done1), .product(prod1));

  booth_r4_mult #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm_v[2]),
    .multiplicand(m_v[2]), .multiplier(q_v[2]),
    .busy(busy2), .done(done2), .product(prod2));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int width_of(int k);
    case (k)
      0:       return 16;
      1:       return 4;
      default: return 32;
    endcase
  endfunction

  function automatic logic get_busy(int k);
    case (k)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_done(int k);
    case (k)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic [63:0] get_prod(int k);
    case (k)
      0:       return {32'd0, prod0};
      1:       return {56'd0, prod1};
      default: return prod2;
    endcase
  endfunction

  // Reference: interpret operands as w-bit signed/unsigned integers,
  // multiply exactly (mod 2^64) and keep the low 2w bits.
  function automatic logic [63:0] ref_mul(int w, bit sm, logic [31:0] m, logic [31:0] q);
    logic [63:0] a, b, p, mask_w, mask_p;
    mask_w = (64'd1 << w) - 64'd1;
    a = {32'd0, m} & mask_w;
    b = {32'd0, q} & mask_w;
    if (sm && a[w-1]) a = a - (64'd1 << w);
    if (sm && b[w-1]) b = b - (64'd1 << w);
    p = a * b;
    mask_p = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return p & mask_p;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_idle(input int k);
    int guard;
    guard = 0;
    while (get_busy(k) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (get_busy(k)) chk("idle_timeout", 64'(get_busy(k)), 64'd0);
  endtask

  // One operation: start for a single cycle, count edges until done.
  task automatic run_op(input int k, input bit sm, input logic [31:0] m, input logic [31:0] q,
                        output logic [63:0] p, output int lat);
    wait_idle(k);
    @(negedge clk);
    sm_v[k] = sm; m_v[k] = m; q_v[k] = q; start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    lat = 0;
    while (!get_done(k) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    p = get_prod(k);
  endtask

  task automatic set_ops(input int k, input int i, input bit exh);
    logic [8:0] idx;
    idx = 9'(i);
    if (exh) begin
      sm_v[k] = idx[8];
      m_v[k]  = {28'd0, idx[7:4]};
      q_v[k]  = {28'd0, idx[3:0]};
    end else begin
      sm_v[k] = 1'($urandom_range(0, 1));
      m_v[k]  = $urandom;
      q_v[k]  = $urandom;
      // Bias toward extremes now and then.
      if ($urandom_range(0, 7) == 0) m_v[k] = 32'h8000_0000 >> (32 - width_of(k));
      if ($urandom_range(0, 7) == 0) q_v[k] = 32'hFFFF_FFFF;
    end
  endtask

  // Back-to-back operations with start held high the whole time.
  task automatic b2b(input int k, input int n, input bit exh);
    int w, cyc;
    logic [63:0] exp;
    w = width_of(k);
    wait_idle(k);
    @(negedge clk);
    set_ops(k, 0, exh);
    start_v[k] = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (!get_busy(k) && cyc < 50);
      if (!get_busy(k)) begin
        chk("b2b_accept_timeout", 64'd0, 64'd1);
        break;
      end
      if (i > 0) chk("b2b_gap", 64'(cyc), 64'd2);
      exp = ref_mul(w, sm_v[k], m_v[k], q_v[k]);
      if (i + 1 < n) set_ops(k, i + 1, exh);
      else start_v[k] = 1'b0;
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (!get_done(k) && cyc < 100);
      chk("b2b_latency", 64'(cyc), 64'(w / 2 + 1));
      chk("b2b_product", get_prod(k), exp);
    end
    start_v[k] = 1'b0;
  endtask

  typedef struct {
    bit          sm;
    logic [15:0] m;
    logic [15:0] q;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p, exp_a;
    int lat, seen;

    tbl[0]  = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000};
    tbl[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    tbl[2]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
    tbl[3]  = '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF};
    tbl[4]  = '{1'b1, 16'h0000, 16'h1234, 32'h0000_0000};
    tbl[5]  = '{1'b0, 16'h8000, 16'h8000, 32'h4000_0000};
    tbl[6]  = '{1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000};
    tbl[7]  = '{1'b1, 16'hFFFF, 16'h0002, 32'hFFFF_FFFE};
    tbl[8]  = '{1'b0, 16'hFFFF, 16'h0002, 32'h0001_FFFE};
    tbl[9]  = '{1'b0, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
    tbl[10] = '{1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; sm_v[k] = 1'b0; m_v[k] = '0; q_v[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy0), 64'd0);
    chk("reset_done", 64'(done0), 64'd0);
    chk("reset_product16", get_prod(0), 64'd0);
    chk("reset_product32", get_prod(2), 64'd0);
    rst = 1'b0;

    // Directed table, WIDTH=16: start in cycle 1 -> done in cycle 10.
    for (int i = 0; i < 11; i++) begin
      run_op(0, tbl[i].sm, {16'd0, tbl[i].m}, {16'd0, tbl[i].q}, p, lat);
      chk($sformatf("tbl%0d_product", i), p, {32'd0, tbl[i].exp});
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd9);
    end

    // Most-negative operands at WIDTH=32 and WIDTH=4.
    run_op(2, 1'b1, 32'h8000_0000, 32'h8000_0000, p, lat);
    chk("w32_minneg_product", p, 64'h4000_0000_0000_0000);
    chk("w32_latency", 64'(lat), 64'd17);
    run_op(1, 1'b1, 32'h8, 32'h7, p, lat);
    chk("w4_minneg_product", p, 64'hC8);
    chk("w4_latency", 64'(lat), 64'd3);

    // start re-pulsed during RUN and during the DONE cycle is ignored.
    wait_idle(0);
    @(negedge clk);
    sm_v[0] = 1'b1; m_v[0] = 32'h1234; q_v[0] = 32'hFEDC; start_v[0] = 1'b1;
    exp_a = ref_mul(16, 1'b1, 32'h1234, 32'hFEDC);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("busy_after_accept", 64'(busy0), 64'd1);
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    sm_v[0] = 1'b0; m_v[0] = 32'hFFFF; q_v[0] = 32'hFFFF; start_v[0] = 1'b1;
    @(posedge clk); #1; lat++;
    start_v[0] = 1'b0;
    while (!done0 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("repulse_latency", 64'(lat), 64'd9);
    chk("repulse_product", get_prod(0), exp_a);
    chk("busy_in_done", 64'(busy0), 64'd1);
    m_v[0] = 32'h3; q_v[0] = 32'h3; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("done_cycle_start_busy", 64'(busy0), 64'd0);
    chk("done_single_pulse", 64'(done0), 64'd0);
    @(posedge clk); #1;
    chk("done_cycle_start_ignored", 64'(busy0), 64'd0);
    chk("product_held", get_prod(0), exp_a);

    // Reset in RUN cycle 4 aborts; a fresh start then completes normally.
    wait_idle(0);
    @(negedge clk);
    sm_v[0] = 1'b0; m_v[0] = 32'hABCD; q_v[0] = 32'h1357; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_done", 64'(done0), 64'd0);
    chk("abort_product", get_prod(0), 64'd0);
    seen = 0;
    repeat (11) begin @(posedge clk); #1; if (done0) seen++; end
    chk("abort_no_done", 64'(seen), 64'd0);
    run_op(0, 1'b1, 32'h0000_8001, 32'h0000_7FFF, p, lat);
    chk("after_abort_product", p, ref_mul(16, 1'b1, 32'h8001, 32'h7FFF));
    chk("after_abort_latency", 64'(lat), 64'd9);

    // Back-to-back streams: random W=16, exhaustive W=4, random W=32.
    b2b(0, 2000, 1'b0);
    b2b(1, 512, 1'b1);
    b2b(2, 300, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
